// File: rtl/riscv_imem_pkg.sv
// Shared types and defaults for the instruction-memory responder.
// Imported by the responder and its line array.
package riscv_imem_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 23;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/riscv_imem_array.sv
// Line storage: one write port, one registered read port.
// Contents survive reset; a same-edge write is not visible to the read.
module riscv_imem_array
  import riscv_imem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX        = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/riscv_imem_responder.sv
// Fixed-latency line responder for the icache refill FSM.
// Accept -> count down -> read on DONE entry -> one-cycle ready pulse.
module riscv_imem_responder
  import riscv_imem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int S_ADDR     = ADDR_W,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  i_riscv_imem_clk,
  input  logic                  i_riscv_imem_rst,
  input  logic                  i_riscv_imem_rden,
  input  logic [S_ADDR-1:0]     i_riscv_imem_addr,
  input  logic                  i_riscv_imem_wr_en,
  input  logic [S_ADDR-1:0]     i_riscv_imem_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_riscv_imem_wr_data,
  output logic                  o_riscv_imem_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_imem_data_out
);

  localparam int IDX = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX-1:0]        idx, idx_n;
  logic                  rd_en;
  logic [IDX-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  // Lines alias modulo MEM_DEPTH; upper address bits are dropped.
  logic unused_bits;
  assign unused_bits = ^{i_riscv_imem_addr[S_ADDR-1:IDX],
                         i_riscv_imem_wr_addr[S_ADDR-1:IDX]};

  riscv_imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX        (IDX)
  ) u_array (
    .clk     (i_riscv_imem_clk),
    .wr_en   (i_riscv_imem_wr_en),
    .wr_idx  (i_riscv_imem_wr_addr[IDX-1:0]),
    .wr_data (i_riscv_imem_wr_data),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    rd_en   = 1'b0;
    rd_idx  = idx;
    unique case (state)
      IDLE: begin
        // LATENCY=1 reads straight from the live address.
        rd_idx = i_riscv_imem_addr[IDX-1:0];
        if (i_riscv_imem_rden) begin
          idx_n = i_riscv_imem_addr[IDX-1:0];
          cnt_n = CNT_LOAD;
          if (LATENCY == 1) begin
            state_n = DONE;
            rd_en   = 1'b1;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (!i_riscv_imem_rden) begin
          state_n = IDLE;
        end else begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end
          if (cnt <= CNT_W'(1)) begin
            state_n = DONE;
            rd_en   = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_riscv_imem_clk or negedge i_riscv_imem_rst) begin
    if (!i_riscv_imem_rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      idx                   <= '0;
      o_riscv_imem_ready    <= 1'b0;
      o_riscv_imem_data_out <= '0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      idx                <= idx_n;
      o_riscv_imem_ready <= (state == DONE);
      if (state == DONE) begin
        o_riscv_imem_data_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_riscv_imem_responder.sv
// Scoreboard bench for riscv_imem_responder (LATENCY=4 and LATENCY=1 builds).
module tb_riscv_imem_responder;

  localparam int DW = 128;
  localparam int AW = 23;
  localparam int L4 = 4;

  localparam logic [DW-1:0] LINE5  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [DW-1:0] LINE6  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [DW-1:0] LINE7A = 128'hA7A7A7A7_00000007_CAFEF00D_77777777;
  localparam logic [DW-1:0] LINE7B = 128'hB7B7B7B7_11111117_DEADBEEF_88888888;
  localparam logic [DW-1:0] LINE9  = 128'h99999999_99999999_99999999_99999999;
  localparam logic [DW-1:0] LINE3  = 128'h33333333_0000ABCD_33333333_0000DCBA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rden = 1'b0;
  logic          rden1 = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ready, ready1;
  logic [DW-1:0] dout, dout1;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int pulses1 = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model[int];

  always #5 clk = ~clk;

  riscv_imem_responder #(
    .DATA_WIDTH (DW),
    .S_ADDR     (AW),
    .MEM_DEPTH  (1024),
    .LATENCY    (L4)
  ) dut (
    .i_riscv_imem_clk      (clk),
    .i_riscv_imem_rst      (rst_n),
    .i_riscv_imem_rden     (rden),
    .i_riscv_imem_addr     (addr),
    .i_riscv_imem_wr_en    (wr_en),
    .i_riscv_imem_wr_addr  (wr_addr),
    .i_riscv_imem_wr_data  (wr_data),
    .o_riscv_imem_ready    (ready),
    .o_riscv_imem_data_out (dout)
  );

  riscv_imem_responder #(
    .DATA_WIDTH (DW),
    .S_ADDR     (AW),
    .MEM_DEPTH  (1024),
    .LATENCY    (1)
  ) dut_l1 (
    .i_riscv_imem_clk      (clk),
    .i_riscv_imem_rst      (rst_n),
    .i_riscv_imem_rden     (rden1),
    .i_riscv_imem_addr     (addr),
    .i_riscv_imem_wr_en    (wr_en),
    .i_riscv_imem_wr_addr  (wr_addr),
    .i_riscv_imem_wr_data  (wr_data),
    .o_riscv_imem_ready    (ready1),
    .o_riscv_imem_data_out (dout1)
  );

  always @(negedge clk) begin
    if (ready === 1'b1) pulses++;
    if (ready1 === 1'b1) pulses1++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bd_write(input int line, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(line);
    wr_data = data;
    step(1);
    wr_en   = 1'b0;
    model[line % 1024] = data;
  endtask

  task automatic wait_ready(input bit which, input int max,
                            output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < max) begin
      step(1);
      n++;
      seen = which ? (ready1 === 1'b1) : (ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    n_cmp++;
    if (dout !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", dout);
    end
    n_cmp++;
    if (ready1 !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready_l1: got %b want 0", ready1);
    end
    n_cmp++;
    if (dout1 !== '0) begin
      n_bad++; $display("FAIL reset_data_l1: got %h want 0", dout1);
    end
    step(1);
    rst_n = 1'b1;
    step(3);
    n_cmp++;
    if (pulses + pulses1 !== 0) begin
      n_bad++; $display("FAIL reset_idle_pulses: got %0d want 0", pulses + pulses1);
    end
  endtask

  task automatic test_basic();
    int n; bit seen; int p0; logic [DW-1:0] e;
    bd_write(9, LINE9);
    bd_write(5, LINE5);
    p0 = pulses;
    addr = 5;
    rden = 1'b1;
    exp_q.push_back(model[5]);
    step(1);
    addr = 9;
    wait_ready(0, 20, n, seen);
    rden = 1'b0;
    n_cmp++;
    if (!seen || n !== L4) begin
      n_bad++; $display("FAIL basic_latency: got %0d (seen %b) want %0d", n, seen, L4);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout !== e) begin
      n_bad++; $display("FAIL basic_data: got %h want %h", dout, e);
    end
    step(1);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_one_cycle: got %b want 0", ready);
    end
    step(5);
    n_cmp++;
    if (dout !== LINE5) begin
      n_bad++; $display("FAIL basic_hold: got %h want %h", dout, LINE5);
    end
    n_cmp++;
    if (pulses - p0 !== 1) begin
      n_bad++; $display("FAIL basic_pulses: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit seen; int p0; logic [DW-1:0] e;
    bd_write(6, LINE6);
    p0 = pulses;
    addr = 5;
    rden = 1'b1;
    exp_q.push_back(model[5]);
    wait_ready(0, 20, n, seen);
    n_cmp++;
    if (!seen || n !== L4 + 1) begin
      n_bad++; $display("FAIL b2b_first_latency: got %0d want %0d", n, L4 + 1);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout !== e) begin
      n_bad++; $display("FAIL b2b_first_data: got %h want %h", dout, e);
    end
    addr = 6;
    exp_q.push_back(model[6]);
    wait_ready(0, 20, n, seen);
    rden = 1'b0;
    n_cmp++;
    if (!seen || n !== L4 + 1) begin
      n_bad++; $display("FAIL b2b_second_latency: got %0d want %0d", n, L4 + 1);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout !== e) begin
      n_bad++; $display("FAIL b2b_second_data: got %h want %h", dout, e);
    end
    step(10);
    n_cmp++;
    if (pulses - p0 !== 2) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses - p0);
    end
  endtask

  task automatic test_abort();
    int n; bit seen; int p0; logic [DW-1:0] e;
    bd_write(7, LINE7A);
    p0 = pulses;
    addr = 7;
    rden = 1'b1;
    step(2);
    rden = 1'b0;
    step(8);
    n_cmp++;
    if (pulses - p0 !== 0) begin
      n_bad++; $display("FAIL abort_pulses: got %0d want 0", pulses - p0);
    end
    n_cmp++;
    if (dout !== model[6]) begin
      n_bad++; $display("FAIL abort_data: got %h want %h", dout, model[6]);
    end
    rden = 1'b1;
    exp_q.push_back(model[7]);
    wait_ready(0, 20, n, seen);
    rden = 1'b0;
    n_cmp++;
    if (!seen || n !== L4 + 1) begin
      n_bad++; $display("FAIL abort_then_idle: got %0d want %0d", n, L4 + 1);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout !== e) begin
      n_bad++; $display("FAIL abort_then_data: got %h want %h", dout, e);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit seen; int p0; logic [DW-1:0] e;
    step(2);
    p0 = pulses;
    addr = 5;
    rden = 1'b1;
    step(2);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_ready: got %b want 0", ready);
    end
    n_cmp++;
    if (dout !== '0) begin
      n_bad++; $display("FAIL rstmid_data: got %h want 0", dout);
    end
    step(1);
    rden = 1'b0;
    step(1);
    #3;
    rst_n = 1'b1;
    step(10);
    n_cmp++;
    if (pulses - p0 !== 0) begin
      n_bad++; $display("FAIL rstmid_pulses: got %0d want 0", pulses - p0);
    end
    rden = 1'b1;
    exp_q.push_back(model[5]);
    wait_ready(0, 20, n, seen);
    rden = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || dout !== e) begin
      n_bad++; $display("FAIL rstmid_array_kept: got %h want %h", dout, e);
    end
  endtask

  task automatic test_alias_collision();
    int n; bit seen; logic [DW-1:0] e;
    step(2);
    addr = AW'(1024 + 7);
    rden = 1'b1;
    exp_q.push_back(model[(1024 + 7) % 1024]);
    wait_ready(0, 20, n, seen);
    rden = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || dout !== e) begin
      n_bad++; $display("FAIL alias_data: got %h want %h", dout, e);
    end
    step(1);
    addr = 7;
    rden = 1'b1;
    exp_q.push_back(model[7]);
    step(L4 - 1);
    wr_en   = 1'b1;
    wr_addr = 7;
    wr_data = LINE7B;
    step(1);
    wr_en = 1'b0;
    model[7] = LINE7B;
    step(1);
    rden = 1'b0;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++; $display("FAIL collide_ready: got %b want 1", ready);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout !== e) begin
      n_bad++; $display("FAIL collide_old: got %h want %h", dout, e);
    end
    step(1);
    rden = 1'b1;
    exp_q.push_back(model[7]);
    wait_ready(0, 20, n, seen);
    rden = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || dout !== e) begin
      n_bad++; $display("FAIL collide_new: got %h want %h", dout, e);
    end
  endtask

  task automatic test_latency1();
    int n; bit seen; int p1; logic [DW-1:0] e;
    bd_write(3, LINE3);
    step(1);
    p1 = pulses1;
    addr = 3;
    rden1 = 1'b1;
    exp_q.push_back(model[3]);
    wait_ready(1, 10, n, seen);
    n_cmp++;
    if (!seen || n !== 2) begin
      n_bad++; $display("FAIL l1_latency: got %0d want 2", n);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout1 !== e) begin
      n_bad++; $display("FAIL l1_data: got %h want %h", dout1, e);
    end
    addr = 5;
    exp_q.push_back(model[5]);
    wait_ready(1, 10, n, seen);
    rden1 = 1'b0;
    n_cmp++;
    if (!seen || n !== 2) begin
      n_bad++; $display("FAIL l1_b2b_latency: got %0d want 2", n);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (dout1 !== e) begin
      n_bad++; $display("FAIL l1_b2b_data: got %h want %h", dout1, e);
    end
    step(6);
    n_cmp++;
    if (pulses1 - p1 !== 2) begin
      n_bad++; $display("FAIL l1_pulses: got %0d want 2", pulses1 - p1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_alias_collision();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
